// File: rtl/mod8_upcounter.sv
// Enable-gated modulo-MOD up counter with a registered wrap-toggle LED.
// Intended as a standalone leaf in the lab top level, fed by a slow clock.
module mod8_upcounter #(
   parameter int MOD   = 8,
   parameter int WIDTH = 3
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             I,
   output logic [WIDTH-1:0] Q,
   output logic             LED
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MOD - 1);

   logic beyond;

   // Codes above MOD-1 only exist when MOD leaves part of the code space unused.
   generate
      if (MOD < (1 << WIDTH)) begin : g_partial
         assign beyond = (Q > LAST);
      end else begin : g_full
         assign beyond = 1'b0;
      end
   endgenerate

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         Q   <= '0;
         LED <= 1'b0;
      end else if (I) begin
         if (Q == LAST) begin
            Q   <= '0;
            LED <= ~LED;
         end else if (beyond) begin
            Q   <= '0;
         end else begin
            Q   <= Q + WIDTH'(1);
         end
      end
   end

endmodule

// File: tb/tb_mod8_upcounter.sv
// Randomised scoreboard bench for mod8_upcounter: the driver pushes expected
// outputs from an arithmetic model, and a monitor pops and compares them.
module tb_mod8_upcounter;

   localparam int MOD   = 8;
   localparam int WIDTH = 3;

   logic             CLK;
   logic             RST;
   logic             I;
   logic [WIDTH-1:0] Q;
   logic             LED;

   typedef struct {
      int q;
      bit led;
   } exp_t;

   exp_t sb[$];
   event async_ev;

   int vectors = 0;
   int miscompares = 0;

   // Reference model: a plain integer count and a wrap counter whose parity is the LED.
   int model_count = 0;
   int model_wraps = 0;

   mod8_upcounter #(.MOD(MOD), .WIDTH(WIDTH)) dut (
      .CLK(CLK),
      .RST(RST),
      .I  (I),
      .Q  (Q),
      .LED(LED)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic exp_t modelStep(input bit rst_level, input bit en);
      exp_t e;
      if (!rst_level) begin
         model_count = 0;
         model_wraps = 0;
      end else if (en) begin
         model_count = model_count + 1;
         if (model_count == MOD) begin
            model_count = 0;
            model_wraps = model_wraps + 1;
         end
      end
      e.q   = model_count;
      e.led = (model_wraps % 2) == 1;
      return e;
   endfunction

   task automatic applyStimulus(input bit rst_level, input bit en);
      @(negedge CLK);
      RST = rst_level;
      I   = en;
      sb.push_back(modelStep(rst_level, en));
   endtask

   // Reset dropped halfway between edges must clear the outputs before the next edge.
   task automatic asyncReset();
      @(negedge CLK);
      #2;
      RST = 1'b0;
      sb.push_back(modelStep(1'b0, I));
      ->async_ev;
   endtask

   // Reset asserted exactly on a rising edge while the counter sits at its last value.
   task automatic resetAtEdge();
      @(negedge CLK);
      I = 1'b1;
      sb.push_back(modelStep(1'b0, 1'b1));
      @(posedge CLK);
      RST = 1'b0;
   endtask

   task automatic checkOutput(input exp_t e);
      vectors++;
      if (Q !== WIDTH'(e.q) || LED !== e.led) begin
         miscompares++;
         $display("[TB] FAIL q_led vec %0d @%0t: got Q=%0d LED=%b, expected Q=%0d LED=%b",
                  vectors, $time, Q, LED, e.q, e.led);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge CLK or async_ev);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      RST = 1'b0;
      I   = 1'b0;
      #3;
      sb.push_back(modelStep(1'b0, 1'b0));
      ->async_ev;

      repeat (2) applyStimulus(1'b0, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b0);
      repeat (4) applyStimulus(1'b1, 1'b1);
      repeat (3) applyStimulus(1'b1, 1'b0);
      repeat (2) applyStimulus(1'b1, 1'b1);
      asyncReset();
      repeat (4) applyStimulus(1'b0, 1'b1);
      repeat (24) applyStimulus(1'b1, 1'b1);
      repeat (7) applyStimulus(1'b1, 1'b1);
      resetAtEdge();
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b1);

      for (int n = 0; n < 300; n++) begin
         int r;
         r = $urandom_range(0, 99);
         if (r < 2) begin
            asyncReset();
         end else if (r < 5) begin
            applyStimulus(1'b0, 1'($urandom_range(0, 1)));
         end else begin
            applyStimulus(1'b1, ($urandom_range(0, 99) < 70));
         end
      end

      repeat (3) @(negedge CLK);
      vectors++;
      if (sb.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL drain: got %0d pending, expected 0", sb.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
